// File: rtl/axil_timer.sv
`default_nettype none
// ============================================================================
// axil_timer : AXI-Lite machine timer (64-bit mtime/mtimecmp, prescaler, irq)
// Rev 1.0
// ============================================================================
module axil_timer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int STRB_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  irq
);

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_MTIME_LO = 3'd2;
   localparam logic [2:0] REG_MTIME_HI = 3'd3;
   localparam logic [2:0] REG_CMP_LO   = 3'd4;
   localparam logic [2:0] REG_CMP_HI   = 3'd5;
   localparam logic [2:0] REG_STATUS   = 3'd6;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;

   logic        en;
   logic        irq_en;
   logic [15:0] prescale;
   logic [15:0] pc;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [31:0] hi_shadow;

   logic        wr_fire, rd_fire;
   logic [2:0]  wr_idx, rd_idx;
   logic        wr_mapped, rd_mapped;
   logic        tick, cmp_ge;
   logic [31:0] wr_cur, wr_word, rd_value;
   logic        unused_bits;

   assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

   // Ready is gated by rst so every output reads 0 while reset is held.
   assign wr_fire        = s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid & ~rst;
   assign rd_fire        = s_axil_arvalid & ~s_axil_rvalid & ~rst;
   assign s_axil_awready = wr_fire;
   assign s_axil_wready  = wr_fire;
   assign s_axil_arready = rd_fire;

   assign wr_idx    = s_axil_awaddr[4:2];
   assign rd_idx    = s_axil_araddr[4:2];
   assign wr_mapped = (s_axil_awaddr[ADDR_WIDTH-1:5] == '0) && (wr_idx != 3'd7);
   assign rd_mapped = (s_axil_araddr[ADDR_WIDTH-1:5] == '0) && (rd_idx != 3'd7);

   assign tick   = en && (pc == prescale);
   assign cmp_ge = (mtime >= mtimecmp);
   assign irq    = irq_en & cmp_ge;

   always_comb begin
      wr_cur = 32'd0;
      case (wr_idx)
         REG_CTRL:     wr_cur = {30'd0, irq_en, en};
         REG_PRESCALE: wr_cur = {16'd0, prescale};
         REG_MTIME_LO: wr_cur = mtime[31:0];
         REG_MTIME_HI: wr_cur = mtime[63:32];
         REG_CMP_LO:   wr_cur = mtimecmp[31:0];
         REG_CMP_HI:   wr_cur = mtimecmp[63:32];
         default:      wr_cur = 32'd0;
      endcase
      wr_word = wr_cur;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (s_axil_wstrb[i]) wr_word[8*i +: 8] = s_axil_wdata[8*i +: 8];
      end
   end

   always_comb begin
      rd_value = 32'd0;
      case (rd_idx)
         REG_CTRL:     rd_value = {30'd0, irq_en, en};
         REG_PRESCALE: rd_value = {16'd0, prescale};
         REG_MTIME_LO: rd_value = mtime[31:0];
         REG_MTIME_HI: rd_value = hi_shadow;
         REG_CMP_LO:   rd_value = mtimecmp[31:0];
         REG_CMP_HI:   rd_value = mtimecmp[63:32];
         REG_STATUS:   rd_value = {31'd0, cmp_ge};
         default:      rd_value = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en            <= 1'b0;
         irq_en        <= 1'b0;
         prescale      <= 16'd0;
         pc            <= 16'd0;
         mtime         <= 64'd0;
         mtimecmp      <= '1;
         hi_shadow     <= 32'd0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
         s_axil_rresp  <= RESP_OKAY;
      end else begin
         if (wr_fire && wr_mapped && wr_idx == REG_CTRL) begin
            en     <= wr_word[0];
            irq_en <= wr_word[1];
         end
         if (wr_fire && wr_mapped && wr_idx == REG_PRESCALE) prescale <= wr_word[15:0];

         if (wr_fire && wr_mapped && wr_idx == REG_PRESCALE) pc <= 16'd0;
         else if (tick)                                       pc <= 16'd0;
         else if (en)                                         pc <= pc + 16'd1;

         // A write to either half suppresses that edge's tick entirely, so no
         // carry leaks into the half that was not written.
         if (wr_fire && wr_mapped && wr_idx == REG_MTIME_LO)      mtime[31:0]  <= wr_word;
         else if (wr_fire && wr_mapped && wr_idx == REG_MTIME_HI) mtime[63:32] <= wr_word;
         else if (tick)                                           mtime        <= mtime + 64'd1;

         if (wr_fire && wr_mapped && wr_idx == REG_CMP_LO) mtimecmp[31:0]  <= wr_word;
         if (wr_fire && wr_mapped && wr_idx == REG_CMP_HI) mtimecmp[63:32] <= wr_word;

         if (wr_fire) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
         end

         if (rd_fire) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_mapped ? rd_value : 32'd0;
            s_axil_rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            if (rd_mapped && rd_idx == REG_MTIME_LO) hi_shadow <= mtime[63:32];
         end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axil_timer.sv
`default_nettype none
// ============================================================================
// tb_axil_timer : randomized self-checking bench for axil_timer
// Rev 1.0
// ============================================================================
module tb_axil_timer;

   localparam logic [11:0] A_CTRL = 12'h00, A_PRE = 12'h04, A_LO = 12'h08, A_HI = 12'h0C;
   localparam logic [11:0] A_CLO = 12'h10, A_CHI = 12'h14, A_STAT = 12'h18;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, irq;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int unsigned cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axil_timer dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .irq(irq)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int unsigned e);
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(awready && wready) && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("aw_timeout", 64'd0, 64'd1);
      e = cyc + 1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bvalid && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("b_timeout", 64'd0, 64'd1);
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int unsigned e);
      int n;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("ar_timeout", 64'd0, 64'd1);
      e = cyc + 1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rvalid && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("r_timeout", 64'd0, 64'd1);
      d = rdata; resp = rresp;
      @(posedge clk); #1;
   endtask

   task automatic wr_e(input logic [11:0] a, input logic [31:0] d, output int unsigned e);
      logic [1:0] r;
      axi_write(a, d, 4'hF, r, e);
      check("bresp_okay", 64'(r), 64'd0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      int unsigned e;
      wr_e(a, d, e);
   endtask

   task automatic rd_e(input logic [11:0] a, output logic [31:0] d, output int unsigned e);
      logic [1:0] r;
      axi_read(a, d, r, e);
      check("rresp_okay", 64'(r), 64'd0);
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      int unsigned e;
      rd_e(a, d, e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference: after enabling at edge e with a cleared prescaler, mtime advances
   // once per (p+1) edges; a read accepted at edge r sees the count after edge r-1.
   task automatic run_count(input logic [15:0] p, input logic [63:0] base, input int len,
                            input string tag, output logic [63:0] final_val);
      int unsigned e, d, r, per;
      logic [31:0] lo, hi, lo2;
      logic [63:0] exp;
      per = 32'(p) + 1;
      wr(A_CTRL, 32'd0);
      wr(A_LO, base[31:0]);
      wr(A_HI, base[63:32]);
      wr(A_PRE, 32'(p));
      wr_e(A_CTRL, 32'd1, e);
      cycles(len);
      rd_e(A_LO, lo, r);
      exp = base + 64'((r - 1 - e) / per);
      check({tag, "_run_lo"}, 64'(lo), 64'(exp[31:0]));
      wr_e(A_CTRL, 32'd0, d);
      exp = base + 64'((d - e) / per);
      rd(A_LO, lo);
      rd(A_HI, hi);
      check({tag, "_frozen"}, {hi, lo}, exp);
      cycles(7);
      rd(A_LO, lo2);
      check({tag, "_hold"}, 64'(lo2), 64'(exp[31:0]));
      final_val = exp;
   endtask

   initial begin
      logic [31:0] v, lo, hi;
      logic [1:0]  r;
      logic [63:0] mt, cmpv, base;
      int unsigned e, re;
      int n;
      logic [31:0] rst_vals [7];

      rst = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outs", {awready, wready, bvalid, arready, rvalid, irq, bresp, rresp},
            64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      rst_vals = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 7; i++) begin
         rd(12'(4 * i), v);
         check($sformatf("rst_reg%0d", i), 64'(v), 64'(rst_vals[i]));
      end
      check("rst_irq", 64'(irq), 64'd0);

      // Counting, prescale, carry and wrap.
      run_count(16'd0, 64'd0, 10, "cnt_p0", mt);
      run_count(16'd3, 64'd0, 20, "cnt_p3", mt);
      run_count(16'd0, 64'h0000_0000_FFFF_FFFF, 1, "carry", mt);
      check("carry_hi", 64'(mt[63:32]), 64'd1);
      run_count(16'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "wrap", mt);
      for (int k = 0; k < 6; k++) begin
         base = {$urandom, $urandom};
         run_count(16'($urandom_range(0, 5)), base, int'($urandom_range(0, 30)), "rnd", mt);
         cmpv = mt + 64'($urandom_range(0, 2)) - 64'd1;
         wr(A_CLO, cmpv[31:0]);
         wr(A_CHI, cmpv[63:32]);
         rd(A_STAT, v);
         check("rnd_status", 64'(v), 64'(mt >= cmpv));
         wr(A_CTRL, 32'd2);
         check("rnd_irq", 64'(irq), 64'(mt >= cmpv));
         wr(A_CTRL, 32'd0);
         check("rnd_irq_off", 64'(irq), 64'd0);
      end

      // Coherent 64-bit read across a low-word carry.
      base = 64'h0000_0000_FFFF_FFFE;
      wr(A_LO, base[31:0]);
      wr(A_HI, base[63:32]);
      wr(A_PRE, 32'd1);
      wr_e(A_CTRL, 32'd1, e);
      for (int k = 0; k < 5; k++) begin
         rd_e(A_LO, lo, re);
         rd(A_HI, hi);
         check("coherent", {hi, lo}, base + 64'((re - 1 - e) / 2));
      end
      wr(A_CTRL, 32'd0);

      // Interrupt rise at mtime==0x20, fall on compare rewrite.
      wr(A_LO, 32'd0);
      wr(A_HI, 32'd0);
      wr(A_PRE, 32'd0);
      wr(A_CHI, 32'd0);
      wr(A_CLO, 32'h20);
      check("irq_pre", 64'(irq), 64'd0);
      wr_e(A_CTRL, 32'd3, e);
      n = 0;
      do begin @(negedge clk); n++; end while (cyc < e + 31 && n < 200);
      check("irq_before", 64'(irq), 64'd0);
      @(negedge clk);
      check("irq_rise", 64'(irq), 64'd1);
      repeat (4) begin
         @(negedge clk);
         check("irq_hold", 64'(irq), 64'd1);
      end
      @(posedge clk); #1;
      rd(A_STAT, v);
      check("status_hi", 64'(v), 64'd1);
      wr(A_CLO, 32'h1000);
      check("irq_fall", 64'(irq), 64'd0);
      rd(A_STAT, v);
      check("status_lo", 64'(v), 64'd0);
      wr(A_CLO, 32'd0);
      check("irq_cmp0", 64'(irq), 64'd1);
      wr(A_CTRL, 32'd1);
      check("irq_masked", 64'(irq), 64'd0);
      rd(A_STAT, v);
      check("status_masked", 64'(v), 64'd1);
      wr(A_CTRL, 32'd0);

      // Byte strobes on MTIME_LO.
      wr(A_LO, 32'h1122_3344);
      axi_write(A_LO, 32'hAABB_CCDD, 4'b0001, r, e);
      rd(A_LO, v);
      check("wstrb_b0", 64'(v), 64'h1122_33DD);

      // Unmapped accesses.
      axi_read(12'h040, v, r, e);
      check("unmap_rresp", 64'(r), 64'd2);
      check("unmap_rdata", 64'(v), 64'd0);
      axi_write(12'h01C, 32'd3, 4'hF, r, e);
      check("unmap_bresp_1c", 64'(r), 64'd2);
      axi_write(12'h040, 32'd3, 4'hF, r, e);
      check("unmap_bresp_40", 64'(r), 64'd2);
      rd(A_CTRL, v);
      check("unmap_noeffect", 64'(v), 64'd0);

      // Write-response backpressure: no second accept while bvalid is held.
      awaddr = A_PRE; wdata = 32'd5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      @(negedge clk);
      @(posedge clk); #1;
      wdata = 32'd9;
      repeat (5) begin
         @(negedge clk);
         check("bp_bvalid", 64'(bvalid), 64'd1);
         check("bp_ready", 64'({awready, wready}), 64'd0);
      end
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; bready = 1;
      cycles(2);
      rd(A_PRE, v);
      check("bp_value", 64'(v), 64'd5);

      // Reset while a write response is pending.
      awaddr = A_PRE; wdata = 32'd7; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      @(negedge clk);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      @(negedge clk);
      check("rstmid_bvalid_pre", 64'(bvalid), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rstmid_bvalid", 64'(bvalid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; bready = 1;
      rd(A_PRE, v);
      check("rstmid_pre", 64'(v), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
